// File: rtl/lsu_pkg.sv
// ----------------------------------------------------------------------------
// lsu_pkg : shared encodings, FSM states and alignment result type for lsu
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package lsu_pkg;

  localparam int c_xlen = 32;

  // funct3 encodings (store side uses b/h/w only)
  localparam logic [2:0] c_f3_b  = 3'b000;
  localparam logic [2:0] c_f3_h  = 3'b001;
  localparam logic [2:0] c_f3_w  = 3'b010;
  localparam logic [2:0] c_f3_bu = 3'b100;
  localparam logic [2:0] c_f3_hu = 3'b101;

  localparam logic [3:0] c_be_none    = 4'b0000;
  localparam logic [3:0] c_be_byte0   = 4'b0001;
  localparam logic [3:0] c_be_lo_half = 4'b0011;
  localparam logic [3:0] c_be_hi_half = 4'b1100;
  localparam logic [3:0] c_be_word    = 4'b1111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DONE  = 2'd2,
    FAULT = 2'd3
  } lsu_state_t;

  typedef struct packed {
    logic [3:0]        be;
    logic [c_xlen-1:0] data;
    logic              misaligned;
    logic              illegal;
  } req_align_t;

endpackage

`default_nettype wire

// File: rtl/lsu_align.sv
// ----------------------------------------------------------------------------
// lsu_align : store lane steering / access checks and load lane extraction
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module lsu_align
  import lsu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             is_store,
  input  logic [2:0]       funct3,
  input  logic [1:0]       addr_lo,
  input  logic [WIDTH-1:0] wdata,
  input  logic [2:0]       ld_funct3,
  input  logic [1:0]       ld_addr_lo,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic [3:0]       be,
  output logic [WIDTH-1:0] lane_wdata,
  output logic             misaligned,
  output logic             illegal,
  output logic [WIDTH-1:0] ld_result
);

  function automatic req_align_t align_req(input logic st, input logic [2:0] f3,
                                           input logic [1:0] lo, input logic [c_xlen-1:0] wd);
    req_align_t r;
    r    = '0;
    r.be = c_be_word;
    case (f3)
      c_f3_b: begin
        if (st) begin
          r.be   = c_be_byte0 << lo;
          r.data = {4{wd[7:0]}};
        end
      end
      c_f3_h: begin
        r.misaligned = lo[0];
        if (st) begin
          r.be   = lo[1] ? c_be_hi_half : c_be_lo_half;
          r.data = {2{wd[15:0]}};
        end
      end
      c_f3_w: begin
        r.misaligned = |lo;
        if (st) r.data = wd;
      end
      c_f3_bu, c_f3_hu: begin
        r.illegal    = st;
        r.misaligned = f3[0] & lo[0];
      end
      default: r.illegal = 1'b1;
    endcase
    return r;
  endfunction

  function automatic logic [c_xlen-1:0] extract_load(input logic [2:0] f3, input logic [1:0] lo,
                                                     input logic [c_xlen-1:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    b = rd[{lo, 3'b000} +: 8];
    h = rd[{lo[1], 4'b0000} +: 16];
    case (f3)
      c_f3_b:  return {{24{b[7]}}, b};
      c_f3_h:  return {{16{h[15]}}, h};
      c_f3_bu: return {24'd0, b};
      c_f3_hu: return {16'd0, h};
      default: return rd;
    endcase
  endfunction

  req_align_t w_req;

  assign w_req      = align_req(is_store, funct3, addr_lo, wdata);
  assign be         = w_req.be;
  assign lane_wdata = w_req.data;
  assign misaligned = w_req.misaligned;
  assign illegal    = w_req.illegal;
  assign ld_result  = extract_load(ld_funct3, ld_addr_lo, mem_rdata);

endmodule

`default_nettype wire

// File: rtl/lsu.sv
// ----------------------------------------------------------------------------
// lsu : RV32I load/store unit with req/ready data-memory handshake
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module lsu
  import lsu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_store,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] wdata,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] rdata,
  output logic             fault,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [3:0]       mem_be,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic             mem_ready,
  input  logic [WIDTH-1:0] mem_rdata
);

  lsu_state_t       r_state;
  logic             r_mem_req;
  logic             r_mem_we;
  logic [WIDTH-1:0] r_mem_addr;
  logic [3:0]       r_mem_be;
  logic [WIDTH-1:0] r_mem_wdata;
  logic             r_done;
  logic             r_fault;
  logic [WIDTH-1:0] r_rdata;
  logic             r_is_store;
  logic [2:0]       r_funct3;
  logic [1:0]       r_addr_lo;

  logic [3:0]       w_be;
  logic [WIDTH-1:0] w_lane_wdata;
  logic             w_misaligned;
  logic             w_illegal;
  logic [WIDTH-1:0] w_ld_result;

  lsu_align #(.WIDTH(WIDTH)) u_align (
    .is_store   (is_store),
    .funct3     (funct3),
    .addr_lo    (addr[1:0]),
    .wdata      (wdata),
    .ld_funct3  (r_funct3),
    .ld_addr_lo (r_addr_lo),
    .mem_rdata  (mem_rdata),
    .be         (w_be),
    .lane_wdata (w_lane_wdata),
    .misaligned (w_misaligned),
    .illegal    (w_illegal),
    .ld_result  (w_ld_result)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_be    <= c_be_none;
      r_mem_wdata <= '0;
      r_done      <= 1'b0;
      r_fault     <= 1'b0;
      r_rdata     <= '0;
      r_is_store  <= 1'b0;
      r_funct3    <= 3'b000;
      r_addr_lo   <= 2'b00;
    end else begin
      case (r_state)
        IDLE: begin
          r_done  <= 1'b0;
          r_fault <= 1'b0;
          if (start) begin
            if (w_misaligned || w_illegal) begin
              r_state <= FAULT;
              r_done  <= 1'b1;
              r_fault <= 1'b1;
              r_rdata <= '0;
            end else begin
              r_state     <= REQ;
              r_mem_req   <= 1'b1;
              r_mem_we    <= is_store;
              r_mem_addr  <= {addr[WIDTH-1:2], 2'b00};
              r_mem_be    <= w_be;
              r_mem_wdata <= w_lane_wdata;
              r_is_store  <= is_store;
              r_funct3    <= funct3;
              r_addr_lo   <= addr[1:0];
            end
          end
        end
        REQ: begin
          // request fields stay frozen until the memory answers
          if (mem_ready) begin
            r_state   <= DONE;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_done    <= 1'b1;
            r_fault   <= 1'b0;
            r_rdata   <= r_is_store ? '0 : w_ld_result;
          end
        end
        DONE, FAULT: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_fault <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // combinational so the core freezes in the very cycle the access is accepted
  assign stall     = ((r_state == IDLE) && start) || (r_state == REQ);
  assign done      = r_done;
  assign fault     = r_fault;
  assign rdata     = r_rdata;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_be    = r_mem_be;
  assign mem_wdata = r_mem_wdata;

endmodule

`default_nettype wire

// File: doc/lsu.md
# lsu

Load/store unit sitting directly downstream of the ALU in the execute path. It consumes the ALU result as an effective address, performs RISC-V RV32I load/store byte-lane alignment, and runs a req/ready handshake with the data memory. While the handshake is outstanding it stalls the core, then returns the sign- or zero-extended load result.

## Interface
- `WIDTH`, 32: data/address width; only 32 is supported.
- `clk`  in  1: clock; all state updates on rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `start`  in  1: current instruction is a load/store; held by the core while `stall`=1.
- `is_store`  in  1: 1 = store, 0 = load.
- `funct3`  in  3: access type; loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW.
- `addr`  in  WIDTH: effective address (ALU output).
- `wdata`  in  WIDTH: store data (rs2).
- `stall`  out  1: core must hold PC and the instruction.
- `done`  out  1: one-cycle pulse; the access completed or faulted.
- `rdata`  out  WIDTH: extended load result; valid while `done`=1.
- `fault`  out  1: with `done`, marks a misaligned access or illegal funct3.
- `mem_req`  out  1: memory request.
- `mem_we`  out  1: memory write enable.
- `mem_addr`  out  WIDTH: word address, with bits [1:0]=00.
- `mem_be`  out  4: byte enables.
- `mem_wdata`  out  WIDTH: lane-replicated store data.
- `mem_ready`  in  1: memory accepts or completes the request in this cycle.
- `mem_rdata`  in  WIDTH: read word; valid when `mem_ready`=1 on a read.

## Operation
- FSM states: IDLE, REQ, DONE, FAULT.
- IDLE + `start`:
  - Legal and aligned: latch `is_store`, `funct3`, `addr[1:0]`, mem_addr, mem_be, mem_wdata; go to REQ.
  - Otherwise: go to FAULT.
- REQ:
  - `mem_req`=1, with `mem_we`/`mem_addr`/`mem_be`/`mem_wdata` held stable.
  - On `mem_ready`=1: capture the extended load result into `rdata` (stores capture 0); go to DONE.
- DONE: `done`=1, `fault`=0; go to IDLE.
- FAULT: `done`=1, `fault`=1, `rdata`=0, no memory access; go to IDLE.
- `start` is ignored in REQ, DONE and FAULT. The next instruction is first sampled in the IDLE cycle after DONE/FAULT.
- Misaligned: half access with addr[0]=1; word access with addr[1:0]≠00.
- Illegal: load funct3 011/110/111; store funct3 ≥011.
- Byte enables:
  - SB: be = 0001 << addr[1:0]; wdata = {4{wdata[7:0]}}.
  - SH: be = addr[1] ? 1100 : 0011; wdata = {2{wdata[15:0]}}.
  - SW: be = 1111.
  - Loads: be = 1111.
- Load extract:
  - Byte = mem_rdata[8*addr[1:0] +: 8].
  - Half = mem_rdata[16*addr[1] +: 16].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- `stall` = (IDLE & `start`) | REQ. It is combinational, so the core is stalled in the acceptance cycle. `stall`=0 in DONE/FAULT, so the core retires the instruction in that cycle.
- Reset mid-REQ: go to IDLE, and `mem_req` drops on the next cycle. The outstanding memory transaction is abandoned; the memory must tolerate request withdrawal.

## Timing
- Reset values:
  - State IDLE.
  - `mem_req`, `mem_we`, `done`, `fault` = 0.
  - `mem_addr`, `mem_wdata`, `rdata` = 0; `mem_be` = 0000.
  - `stall` follows `start`.
- All memory-side outputs and `done`/`fault`/`rdata` are registered.
- Cycle 0: `start` sampled in IDLE (`stall`=1). Cycle 1: `mem_req`=1.
- If `mem_ready`=1 in cycle k (k≥1), then `done`=1 in cycle k+1. Minimum latency from `start` to `done` is 2 cycles.
- Fault path: `done`=`fault`=1 in cycle 1.
- `mem_ready` is ignored outside REQ.
- `mem_req` is never asserted in the same cycle as `done`.
- Back-to-back accesses: at most one access every 3 cycles.

## Structure
- Shared package `lsu_pkg`: funct3 load/store encodings, state enum (IDLE/REQ/DONE/FAULT), byte-enable constants.
- Sub-module `lsu_align` (combinational): two functions.
  - Store side: funct3 + addr[1:0] + wdata → be, lane data, misaligned/illegal flags.
  - Load side: funct3 + addr[1:0] + mem_rdata → extended result.
- Top level holds only the FSM and registers.

## Test plan
- SW addr=0x100, wdata=0xDEADBEEF, `mem_ready` 1 cycle after `mem_req` → mem_addr=0x100, be=1111, mem_we=1; `done` in cycle 3; `fault`=0.
- SB addr=0x203, wdata=0x000000A5 → mem_addr=0x200, be=1000, mem_wdata=0xA5A5A5A5.
- LB addr=0x1, mem_rdata=0x0000_80FF → rdata=0xFFFFFF80. Same access as LBU → rdata=0x00000080. LHU addr=0x2, mem_rdata=0xBEEF1234 → rdata=0x0000BEEF.
- LW addr=0x102 → `done`=`fault`=1 in cycle 1, `mem_req` never asserted. Load funct3=011 → same fault response.
- LW with `mem_ready` delayed 5 cycles → `mem_req`, mem_addr and mem_be stable throughout; `stall`=1 until DONE; `start` toggling during REQ has no effect.
- `rst_n`=0 for one cycle while in REQ → next cycle: IDLE, `mem_req`=0, `done`=0. A subsequent `mem_ready` pulse is ignored.
